// File: rtl/x_operand_pairer_pkg.sv
// rtl/x_operand_pairer_pkg.sv - shared widths, latency constant and log2 helper for the operand pairer
package x_operand_pairer_pkg;

    localparam int DATA_WIDTH           = 64;
    localparam int X_CACHE_PUSH_LATENCY = 3;
    localparam int PAIR_COUNT_WIDTH     = 32;

    typedef struct packed {
        logic                  row_end;
        logic [DATA_WIDTH-1:0] val;
    } val_entry_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/x_operand_pairer_if.sv
// rtl/x_operand_pairer_if.sv - x/value push streams, back-pressure and pair output bundle
interface x_operand_pairer_if;
    import x_operand_pairer_pkg::*;

    logic                        push_x;
    logic [DATA_WIDTH-1:0]       x_val;
    logic                        x_stall;
    logic                        push_val;
    logic [DATA_WIDTH-1:0]       val;
    logic                        val_row_end;
    logic                        val_almost_full;
    logic                        out_stall;
    logic                        push_pair;
    logic [DATA_WIDTH-1:0]       pair_a;
    logic [DATA_WIDTH-1:0]       pair_x;
    logic                        pair_row_end;
    logic [PAIR_COUNT_WIDTH-1:0] pair_count;
    logic                        overflow;

    modport slave (
        input  push_x, x_val, push_val, val, val_row_end, out_stall,
        output x_stall, val_almost_full, push_pair, pair_a, pair_x, pair_row_end,
               pair_count, overflow
    );

    modport master (
        output push_x, x_val, push_val, val, val_row_end, out_stall,
        input  x_stall, val_almost_full, push_pair, pair_a, pair_x, pair_row_end,
               pair_count, overflow
    );

endinterface

// File: rtl/pairer_sync_fifo.sv
// rtl/pairer_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count and drop flag
module pairer_sync_fifo
    import x_operand_pairer_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 32,
    localparam int AW    = log2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/x_operand_pairer.sv
// rtl/x_operand_pairer.sv - pairs buffered x values with matrix values in order for the PE multiplier
module x_operand_pairer
    import x_operand_pairer_pkg::*;
#(
    parameter int X_FIFO_DEPTH   = 32,
    parameter int VAL_FIFO_DEPTH = 32,
    parameter int STALL_MARGIN   = 4,
    parameter int VAL_AF_MARGIN  = 4
) (
    input logic             clk,
    input logic             rst,
    x_operand_pairer_if.slave bus
);

    localparam int XCW = log2(X_FIFO_DEPTH) + 1;
    localparam int VCW = log2(VAL_FIFO_DEPTH) + 1;

    // The x cache keeps pushing for its pipeline depth after it sees the stall.
    if (STALL_MARGIN < X_CACHE_PUSH_LATENCY + 1) begin : g_bad_stall_margin
        $error("STALL_MARGIN too small for the x-cache push pipeline");
    end
    if ((1 << log2(X_FIFO_DEPTH)) != X_FIFO_DEPTH || (1 << log2(VAL_FIFO_DEPTH)) != VAL_FIFO_DEPTH
        || X_FIFO_DEPTH < 2 || VAL_FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO depths must be powers of two and at least 2");
    end

    logic [DATA_WIDTH-1:0]       x_head;
    logic [XCW-1:0]              x_count;
    logic                        x_empty;
    logic                        x_full;
    logic                        x_drop;
    val_entry_t                  v_in;
    val_entry_t                  v_head;
    logic [VCW-1:0]              v_count;
    logic                        v_empty;
    logic                        v_full;
    logic                        v_drop;
    logic                        pop;

    logic                        push_pair_r;
    logic [DATA_WIDTH-1:0]       pair_a_r;
    logic [DATA_WIDTH-1:0]       pair_x_r;
    logic                        pair_row_end_r;
    logic [PAIR_COUNT_WIDTH-1:0] pair_count_r;
    logic                        overflow_r;

    assign v_in = '{row_end: bus.val_row_end, val: bus.val};
    assign pop  = !x_empty && !v_empty && !bus.out_stall;

    pairer_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(X_FIFO_DEPTH)) u_x_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push_x),
        .din   (bus.x_val),
        .pop   (pop),
        .dout  (x_head),
        .count (x_count),
        .empty (x_empty),
        .full  (x_full),
        .drop  (x_drop)
    );

    pairer_sync_fifo #(.WIDTH($bits(val_entry_t)), .DEPTH(VAL_FIFO_DEPTH)) u_val_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push_val),
        .din   (v_in),
        .pop   (pop),
        .dout  (v_head),
        .count (v_count),
        .empty (v_empty),
        .full  (v_full),
        .drop  (v_drop)
    );

    assign bus.x_stall         = (x_count >= XCW'(X_FIFO_DEPTH - STALL_MARGIN));
    assign bus.val_almost_full = (v_count >= VCW'(VAL_FIFO_DEPTH - VAL_AF_MARGIN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            push_pair_r    <= 1'b0;
            pair_a_r       <= '0;
            pair_x_r       <= '0;
            pair_row_end_r <= 1'b0;
            pair_count_r   <= '0;
            overflow_r     <= 1'b0;
        end else begin
            push_pair_r <= pop;
            if (pop) begin
                pair_a_r       <= v_head.val;
                pair_x_r       <= x_head;
                pair_row_end_r <= v_head.row_end;
                pair_count_r   <= pair_count_r + 1'b1;
            end
            if (x_drop || v_drop) overflow_r <= 1'b1;
        end
    end

    assign bus.push_pair    = push_pair_r;
    assign bus.pair_a       = pair_a_r;
    assign bus.pair_x       = pair_x_r;
    assign bus.pair_row_end = pair_row_end_r;
    assign bus.pair_count   = pair_count_r;
    assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_x_operand_pairer.sv
// tb/tb_x_operand_pairer.sv - scoreboard bench for x_operand_pairer
module tb_x_operand_pairer;

    localparam int XD = 32;
    localparam int VD = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    x_operand_pairer_if bus ();

    x_operand_pairer #(
        .X_FIFO_DEPTH   (XD),
        .VAL_FIFO_DEPTH (VD),
        .STALL_MARGIN   (4),
        .VAL_AF_MARGIN  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]  mxq [$];
    logic [64:0]  mvq [$];
    logic [128:0] expq [$];
    logic [31:0]  m_count = '0;
    logic         m_ovf   = 1'b0;
    logic         exp_pp  = 1'b0;
    logic [128:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one clock edge, using the inputs held across it.
    task automatic model_edge(input logic px, input logic [63:0] xv, input logic pv, input logic [64:0] ve);
        logic        pop_m;
        logic [63:0] xh;
        logic [64:0] vh;
        pop_m = (mxq.size() != 0) && (mvq.size() != 0) && !bus.out_stall;
        if (pop_m) begin
            xh = mxq.pop_front();
            vh = mvq.pop_front();
            expq.push_back({vh, xh});
            m_count = m_count + 1;
        end
        exp_pp = pop_m;
        if (px) begin
            if (mxq.size() < XD) mxq.push_back(xv);
            else m_ovf = 1'b1;
        end
        if (pv) begin
            if (mvq.size() < VD) mvq.push_back(ve);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic px, input logic [63:0] xv, input logic pv, input logic [63:0] vv, input logic re);
        bus.push_x      = px;
        bus.x_val       = xv;
        bus.push_val    = pv;
        bus.val         = vv;
        bus.val_row_end = re;
        @(posedge clk);
        model_edge(px, xv, pv, {re, vv});
        #1;
        bus.push_x   = 1'b0;
        bus.push_val = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        mxq.delete();
        mvq.delete();
        expq.delete();
        m_count = '0;
        m_ovf   = 1'b0;
        exp_pp  = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_push_pair", bus.push_pair, 0);
        chk("rst_pair_a", bus.pair_a, 0);
        chk("rst_pair_x", bus.pair_x, 0);
        chk("rst_row_end", bus.pair_row_end, 0);
        chk("rst_pair_count", bus.pair_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_x_stall", bus.x_stall, 0);
        chk("rst_val_af", bus.val_almost_full, 0);
        chk("rst_x_count", dut.u_x_fifo.count, 0);
        chk("rst_val_count", dut.u_val_fifo.count, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("push_pair", bus.push_pair, exp_pp);
            if (bus.push_pair) begin
                chk("pair_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    mon_e = expq.pop_front();
                    chk("pair_a", bus.pair_a, mon_e[127:64]);
                    chk("pair_x", bus.pair_x, mon_e[63:0]);
                    chk("pair_row_end", bus.pair_row_end, mon_e[128]);
                end
            end
            chk("pair_count", bus.pair_count, m_count);
            chk("overflow", bus.overflow, m_ovf);
            chk("x_stall", bus.x_stall, mxq.size() >= XD - 4);
            chk("val_af", bus.val_almost_full, mvq.size() >= VD - 4);
            chk("x_count", dut.u_x_fifo.count, mxq.size());
            chk("val_count", dut.u_val_fifo.count, mvq.size());
        end
    end

    initial begin
        bus.push_x = 1'b0; bus.x_val = '0; bus.push_val = 1'b0;
        bus.val = '0; bus.val_row_end = 1'b0; bus.out_stall = 1'b0;

        // 1: single pair, latency and values
        do_reset();
        check_reset_state();
        step(1'b1, 64'h3FF0_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t1_push_pair", bus.push_pair, 1);
        chk("t1_pair_a", bus.pair_a, 64'h4000_0000_0000_0000);
        chk("t1_pair_x", bus.pair_x, 64'h3FF0_0000_0000_0000);
        chk("t1_count", bus.pair_count, 1);
        idle(2);

        // 2: values first, x later, back-to-back pairs
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 64'h10 + 64'(i), i == 4);
        idle(10);
        for (int i = 0; i < 5; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, '0, 1'b0);
        idle(3);

        // 4: out_stall holds pairs for 6 cycles
        bus.out_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'($urandom));
        idle(3);
        bus.out_stall = 1'b0;
        idle(5);

        // 3 and 5: fill x FIFO, stall threshold, push-with-pop when full, then drop
        for (int i = 0; i < 27; i++) step(1'b1, 64'h200 + 64'(i), 1'b0, '0, 1'b0);
        chk("t3_stall_27", bus.x_stall, 0);
        step(1'b1, 64'h21B, 1'b0, '0, 1'b0);
        chk("t3_stall_28", bus.x_stall, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 64'h300 + 64'(i), 1'b0, '0, 1'b0);
        chk("t3_full_ovf", bus.overflow, 0);
        chk("t3_full_count", dut.u_x_fifo.count, 32);
        step(1'b0, '0, 1'b1, 64'h777, 1'b0);
        step(1'b1, 64'h400, 1'b0, '0, 1'b0);
        chk("t5_count", dut.u_x_fifo.count, 32);
        chk("t5_ovf", bus.overflow, 0);
        step(1'b1, 64'h401, 1'b0, '0, 1'b0);
        chk("t3_drop_ovf", bus.overflow, 1);
        idle(2);

        // value almost-full threshold
        do_reset();
        for (int i = 0; i < 27; i++) step(1'b0, '0, 1'b1, 64'h500 + 64'(i), 1'b0);
        chk("vaf_27", bus.val_almost_full, 0);
        step(1'b0, '0, 1'b1, 64'h51B, 1'b1);
        chk("vaf_28", bus.val_almost_full, 1);

        // 6: reset with buffered data
        do_reset();
        bus.out_stall = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 64'h600 + 64'(i), 1'b1, 64'h700 + 64'(i), 1'b0);
        bus.out_stall = 1'b0;
        do_reset();
        check_reset_state();
        step(1'b1, 64'hAAAA, 1'b1, 64'hBBBB, 1'b1);
        idle(2);
        chk("t6_pair_x", bus.pair_x, 64'hAAAA);

        // 7: pair_count wrap
        force dut.pair_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.pair_count_r;
        m_count = 32'hFFFF_FFFF;
        step(1'b1, 64'h1, 1'b1, 64'h2, 1'b0);
        idle(2);
        chk("t7_wrap", bus.pair_count, 0);

        idle(3);
        chk("drain", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
